// File: rtl/wb_writeback_pkg.sv
// Shared types and constants for the writeback stage.
//   resultsrc_e : result select encoding carried from MEM (2'b11 is reserved, behaves as ALU)
//   wb_state_e  : writeback FSM states
//   F3_*        : funct3 encodings of the load instructions
package wb_writeback_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } resultsrc_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_LOAD = 2'b01,
    ST_WRITE     = 2'b10
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/wb_writeback_if.sv
// MEM -> WB pipeline handshake bundle.
//   master : MEM stage (drives the instruction fields and mem_valid, receives mem_ready)
//   slave  : WB stage  (receives the instruction, drives mem_ready)
// mem_resultsrc is a raw 2-bit field because the encoding 2'b11 is legal on the wire.
interface wb_writeback_if #(
  parameter int WIDTH = 32
);
  logic             mem_valid;
  logic             mem_ready;
  logic             mem_regwrite;
  logic [4:0]       mem_rd;
  logic [1:0]       mem_resultsrc;
  logic [2:0]       mem_funct3;
  logic [WIDTH-1:0] mem_alu_res;
  logic [WIDTH-1:0] mem_pc4;

  modport master (
    output mem_valid, mem_regwrite, mem_rd, mem_resultsrc, mem_funct3, mem_alu_res, mem_pc4,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_regwrite, mem_rd, mem_resultsrc, mem_funct3, mem_alu_res, mem_pc4,
    output mem_ready
  );
endinterface

// File: rtl/wb_writeback_load_extend.sv
// Combinational load-data extraction and extension.
//   rdata_i  : raw aligned word from data memory
//   funct3_i : load type (LB/LH/LW/LBU/LHU; any other code behaves as LW)
//   offset_i : byte offset within the word (address bits [1:0])
//   data_o   : extended result
// Misaligned halfword offsets are not trapped; offset_i[0] is simply ignored for halfwords.
module load_extend
  import wb_writeback_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       offset_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (offset_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_LB:   data_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_LHU:  data_o = {{(WIDTH-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: MEM/WB pipeline register, result select and sole register-file write port.
//   clk, rst_n   : clock and asynchronous active-low reset
//   mem          : MEM -> WB handshake (slave side); transfer = mem_valid & mem_ready at posedge
//   dmem_rvalid  : one-cycle pulse qualifying dmem_rdata for the outstanding load
//   dmem_rdata   : raw aligned word from data memory
//   rf_we/wa/wd  : register-file write port (regfile samples on negedge)
//   fwd_*        : forwarding copy of the pending register-file write
//   instret      : retired-instruction counter, one per WRITE cycle, wraps
module wb_writeback
  import wb_writeback_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_writeback_if.slave    mem,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [WIDTH-1:0] fwd_data,
  output logic [CNT_W-1:0] instret
);

  wb_state_e        state_q, state_d;
  logic             ready;
  logic             accept;
  logic             is_load;
  logic             load_done;

  // Fields of the load waiting for its data
  logic [4:0]       ld_rd_q;
  logic             ld_we_q;
  logic [2:0]       ld_f3_q;
  logic [1:0]       ld_off_q;
  logic [WIDTH-1:0] ld_data;

  logic             rf_we_q;
  logic [4:0]       rf_wa_q;
  logic [WIDTH-1:0] rf_wd_q;
  logic [CNT_W-1:0] instret_q;

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .rdata_i  (dmem_rdata),
    .funct3_i (ld_f3_q),
    .offset_i (ld_off_q),
    .data_o   (ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_LOAD: if (dmem_rvalid) state_d = ST_WRITE;
      default: begin
        if (accept) state_d = is_load ? ST_WAIT_LOAD : ST_WRITE;
        else        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: new work is taken whenever no load is outstanding
  always_comb begin
    ready     = (state_q == ST_IDLE) || (state_q == ST_WRITE);
    accept    = mem.mem_valid && ready;
    is_load   = (mem.mem_resultsrc == RES_LOAD);
    load_done = (state_q == ST_WAIT_LOAD) && dmem_rvalid;
  end

  assign mem.mem_ready = ready;

  // Datapath registers. rf_we_q is only set on entry to WRITE, so it is high exactly in
  // qualifying WRITE cycles; address and data keep their last values otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rd_q   <= '0;
      ld_we_q   <= 1'b0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_wa_q   <= '0;
      rf_wd_q   <= '0;
      instret_q <= '0;
    end else begin
      if (accept && is_load) begin
        ld_rd_q  <= mem.mem_rd;
        ld_we_q  <= mem.mem_regwrite && (mem.mem_rd != 5'd0);
        ld_f3_q  <= mem.mem_funct3;
        ld_off_q <= mem.mem_alu_res[1:0];
      end

      if (accept && !is_load) begin
        rf_we_q <= mem.mem_regwrite && (mem.mem_rd != 5'd0);
        rf_wa_q <= mem.mem_rd;
        // Reserved select 2'b11 falls through to the ALU result
        rf_wd_q <= (mem.mem_resultsrc == RES_PC4) ? mem.mem_pc4 : mem.mem_alu_res;
      end else if (load_done) begin
        rf_we_q <= ld_we_q;
        rf_wa_q <= ld_rd_q;
        rf_wd_q <= ld_data;
      end else begin
        rf_we_q <= 1'b0;
      end

      if (state_q == ST_WRITE) instret_q <= instret_q + 1'b1;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;
  assign fwd_valid = rf_we_q;
  assign fwd_rd    = rf_wa_q;
  assign fwd_data  = rf_wd_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_writeback.sv
module tb_wb_writeback;
  import wb_writeback_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  int chk_cnt;
  int pass_cnt;

  wb_writeback_if #(.WIDTH(32)) mif ();

  wb_writeback #(.WIDTH(32), .CNT_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mif),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    mif.mem_valid     = 1'b0;
    mif.mem_regwrite  = 1'b0;
    mif.mem_rd        = 5'd0;
    mif.mem_resultsrc = 2'b00;
    mif.mem_funct3    = 3'd0;
    mif.mem_alu_res   = 32'd0;
    mif.mem_pc4       = 32'd0;
    dmem_rvalid       = 1'b0;
    dmem_rdata        = 32'd0;
  endtask

  task automatic issue(input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                       input logic rw, input logic [31:0] alu, input logic [31:0] pc4);
    mif.mem_valid     = 1'b1;
    mif.mem_resultsrc = src;
    mif.mem_funct3    = f3;
    mif.mem_rd        = rd;
    mif.mem_regwrite  = rw;
    mif.mem_alu_res   = alu;
    mif.mem_pc4       = pc4;
  endtask

  task automatic do_reset;
    idle_bus();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset;
    idle_bus();
    rst_n = 1'b0;
    step();
    chk_cnt++; if (rf_we !== 1'b0)       $display("FAIL rst_rf_we got %0b want 0", rf_we); else pass_cnt++;
    chk_cnt++; if (rf_wa !== 5'd0)       $display("FAIL rst_rf_wa got %0d want 0", rf_wa); else pass_cnt++;
    chk_cnt++; if (rf_wd !== 32'd0)      $display("FAIL rst_rf_wd got %h want 0", rf_wd); else pass_cnt++;
    chk_cnt++; if (fwd_valid !== 1'b0)   $display("FAIL rst_fwd_valid got %0b want 0", fwd_valid); else pass_cnt++;
    chk_cnt++; if (fwd_rd !== 5'd0)      $display("FAIL rst_fwd_rd got %0d want 0", fwd_rd); else pass_cnt++;
    chk_cnt++; if (fwd_data !== 32'd0)   $display("FAIL rst_fwd_data got %h want 0", fwd_data); else pass_cnt++;
    chk_cnt++; if (instret !== 64'd0)    $display("FAIL rst_instret got %0d want 0", instret); else pass_cnt++;
    chk_cnt++; if (mif.mem_ready !== 1'b1) $display("FAIL rst_mem_ready got %0b want 1", mif.mem_ready); else pass_cnt++;
    rst_n = 1'b1;
    step();
    $display("test_reset done: checks=%0d passed=%0d", chk_cnt, pass_cnt);
  endtask

  task automatic test_alu;
    do_reset();
    issue(RES_ALU, 3'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0);
    chk_cnt++; if (mif.mem_ready !== 1'b1) $display("FAIL alu_ready got %0b want 1", mif.mem_ready); else pass_cnt++;
    step();
    idle_bus();
    chk_cnt++; if (rf_we !== 1'b1)          $display("FAIL alu_we got %0b want 1", rf_we); else pass_cnt++;
    chk_cnt++; if (rf_wa !== 5'd5)          $display("FAIL alu_wa got %0d want 5", rf_wa); else pass_cnt++;
    chk_cnt++; if (rf_wd !== 32'h1234)      $display("FAIL alu_wd got %h want 00001234", rf_wd); else pass_cnt++;
    chk_cnt++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h1234)
      $display("FAIL alu_fwd got v=%0b rd=%0d d=%h want v=1 rd=5 d=00001234", fwd_valid, fwd_rd, fwd_data); else pass_cnt++;
    step();
    chk_cnt++; if (rf_we !== 1'b0)          $display("FAIL alu_we_drop got %0b want 0", rf_we); else pass_cnt++;
    chk_cnt++; if (rf_wd !== 32'h1234)      $display("FAIL alu_wd_hold got %h want 00001234", rf_wd); else pass_cnt++;
    chk_cnt++; if (instret !== 64'd1)       $display("FAIL alu_instret got %0d want 1", instret); else pass_cnt++;
    $display("test_alu done: checks=%0d passed=%0d", chk_cnt, pass_cnt);
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(RES_ALU, 3'd0, 5'(10 + i), 1'b1, 32'h100 + 32'(i), 32'h0);
      chk_cnt++; if (mif.mem_ready !== 1'b1) $display("FAIL b2b_ready%0d got %0b want 1", i, mif.mem_ready); else pass_cnt++;
      step();
      chk_cnt++; if (rf_we !== 1'b1 || rf_wa !== 5'(10 + i) || rf_wd !== 32'h100 + 32'(i))
        $display("FAIL b2b_write%0d got we=%0b wa=%0d wd=%h want we=1 wa=%0d wd=%h",
                 i, rf_we, rf_wa, rf_wd, 10 + i, 32'h100 + 32'(i)); else pass_cnt++;
    end
    idle_bus();
    step();
    chk_cnt++; if (rf_we !== 1'b0)    $display("FAIL b2b_we_drop got %0b want 0", rf_we); else pass_cnt++;
    chk_cnt++; if (instret !== 64'd3) $display("FAIL b2b_instret got %0d want 3", instret); else pass_cnt++;
    $display("test_back_to_back done: checks=%0d passed=%0d", chk_cnt, pass_cnt);
  endtask

  task automatic test_load_lb;
    do_reset();
    issue(RES_LOAD, F3_LB, 5'd7, 1'b1, 32'h0000_1003, 32'h0);
    step();
    idle_bus();
    for (int c = 0; c < 4; c++) begin
      chk_cnt++; if (mif.mem_ready !== 1'b0) $display("FAIL lb_stall%0d got ready=%0b want 0", c, mif.mem_ready); else pass_cnt++;
      chk_cnt++; if (rf_we !== 1'b0)         $display("FAIL lb_nowrite%0d got we=%0b want 0", c, rf_we); else pass_cnt++;
      if (c == 3) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF_FFFF;
      end
      step();
    end
    dmem_rvalid = 1'b0;
    chk_cnt++; if (mif.mem_ready !== 1'b1) $display("FAIL lb_ready_back got %0b want 1", mif.mem_ready); else pass_cnt++;
    chk_cnt++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'hFFFF_FF80)
      $display("FAIL lb_write got we=%0b wa=%0d wd=%h want we=1 wa=7 wd=ffffff80", rf_we, rf_wa, rf_wd); else pass_cnt++;
    step();
    issue(RES_LOAD, F3_LBU, 5'd8, 1'b1, 32'h0000_1003, 32'h0);
    step();
    idle_bus();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    chk_cnt++; if (rf_we !== 1'b1 || rf_wa !== 5'd8 || rf_wd !== 32'h0000_0080)
      $display("FAIL lbu_write got we=%0b wa=%0d wd=%h want we=1 wa=8 wd=00000080", rf_we, rf_wa, rf_wd); else pass_cnt++;
    step();
    chk_cnt++; if (instret !== 64'd2) $display("FAIL lb_instret got %0d want 2", instret); else pass_cnt++;
    $display("test_load_lb done: checks=%0d passed=%0d", chk_cnt, pass_cnt);
  endtask

  task automatic test_load_ext;
    logic [2:0]  tf3  [7];
    logic [1:0]  toff [7];
    logic [31:0] trd  [7];
    logic [31:0] texp [7];
    tf3  = '{F3_LH, F3_LW, F3_LH, F3_LHU, F3_LB, F3_LBU, 3'd3};
    toff = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1};
    trd  = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h1234_8001, 32'h1234_8001,
             32'h0000_8000, 32'h00AB_0000, 32'hDEAD_BEEF};
    texp = '{32'h0000_7FFF, 32'h7FFF_0000, 32'hFFFF_8001, 32'h0000_8001,
             32'hFFFF_FF80, 32'h0000_00AB, 32'hDEAD_BEEF};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      issue(RES_LOAD, tf3[i], 5'd9, 1'b1, {30'h400, toff[i]}, 32'h0);
      step();
      idle_bus();
      dmem_rvalid = 1'b1;
      dmem_rdata  = trd[i];
      step();
      dmem_rvalid = 1'b0;
      chk_cnt++; if (rf_we !== 1'b1 || rf_wd !== texp[i])
        $display("FAIL ext%0d_f3_%0d got we=%0b wd=%h want we=1 wd=%h", i, tf3[i], rf_we, rf_wd, texp[i]); else pass_cnt++;
      step();
    end
    $display("test_load_ext done: checks=%0d passed=%0d", chk_cnt, pass_cnt);
  endtask

  task automatic test_rd0_jal;
    do_reset();
    issue(RES_ALU, 3'd0, 5'd0, 1'b1, 32'h55, 32'h0);
    step();
    idle_bus();
    chk_cnt++; if (rf_we !== 1'b0)    $display("FAIL rd0_we got %0b want 0", rf_we); else pass_cnt++;
    step();
    chk_cnt++; if (instret !== 64'd1) $display("FAIL rd0_instret got %0d want 1", instret); else pass_cnt++;
    issue(RES_PC4, 3'd0, 5'd1, 1'b1, 32'h999, 32'h104);
    step();
    chk_cnt++; if (rf_we !== 1'b1 || rf_wa !== 5'd1 || rf_wd !== 32'h104)
      $display("FAIL jal_write got we=%0b wa=%0d wd=%h want we=1 wa=1 wd=00000104", rf_we, rf_wa, rf_wd); else pass_cnt++;
    issue(RES_ALU, 3'd0, 5'd3, 1'b0, 32'h77, 32'h0);
    step();
    chk_cnt++; if (rf_we !== 1'b0)    $display("FAIL norw_we got %0b want 0", rf_we); else pass_cnt++;
    issue(2'b11, 3'd0, 5'd4, 1'b1, 32'hAA, 32'hBB);
    step();
    idle_bus();
    chk_cnt++; if (rf_we !== 1'b1 || rf_wa !== 5'd4 || rf_wd !== 32'hAA)
      $display("FAIL rsvd_write got we=%0b wa=%0d wd=%h want we=1 wa=4 wd=000000aa", rf_we, rf_wa, rf_wd); else pass_cnt++;
    step();
    chk_cnt++; if (instret !== 64'd4) $display("FAIL rd0_jal_instret got %0d want 4", instret); else pass_cnt++;
    $display("test_rd0_jal done: checks=%0d passed=%0d", chk_cnt, pass_cnt);
  endtask

  task automatic test_reset_mid_load;
    do_reset();
    issue(RES_ALU, 3'd0, 5'd2, 1'b1, 32'h1, 32'h0);
    step();
    issue(RES_LOAD, F3_LW, 5'd6, 1'b1, 32'h2000, 32'h0);
    step();
    idle_bus();
    chk_cnt++; if (mif.mem_ready !== 1'b0) $display("FAIL ml_wait_ready got %0b want 0", mif.mem_ready); else pass_cnt++;
    chk_cnt++; if (instret !== 64'd1)      $display("FAIL ml_pre_instret got %0d want 1", instret); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (mif.mem_ready !== 1'b1) $display("FAIL ml_async_ready got %0b want 1", mif.mem_ready); else pass_cnt++;
    chk_cnt++; if (instret !== 64'd0)      $display("FAIL ml_async_instret got %0d want 0", instret); else pass_cnt++;
    step();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 1'b0;
    chk_cnt++; if (rf_we !== 1'b0 || mif.mem_ready !== 1'b1)
      $display("FAIL ml_stale_rvalid got we=%0b ready=%0b want we=0 ready=1", rf_we, mif.mem_ready); else pass_cnt++;
    step();
    chk_cnt++; if (rf_we !== 1'b0 || instret !== 64'd0 || rf_wd !== 32'd0)
      $display("FAIL ml_after got we=%0b instret=%0d wd=%h want we=0 instret=0 wd=0", rf_we, instret, rf_wd); else pass_cnt++;
    $display("test_reset_mid_load done: checks=%0d passed=%0d", chk_cnt, pass_cnt);
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n    = 1'b0;
    idle_bus();
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_lb();
    test_load_ext();
    test_rd0_jal();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
